sipo_deser: RTL

Parametrised serial-in/parallel-out deserialiser. It is the successor to the fixed-width SIPO register and adds configurable width and bit order, an input valid qualifier, a bit counter, and a valid/ready output holding register with overrun detection. It sits between a serial source (one bit per qualified clock) and a word-wide consumer.

---
 rtl/sipo_deser.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sipo_deser.sv
// sipo_deser: parametrised serial-in/parallel-out deserialiser.
//
// One serial bit is accepted on each clock where din_valid is high.
// WIDTH accepted bits form one word. The finished word moves into a
// valid/ready output holding register. If that register is still full
// when the next word finishes, the new word is dropped and overrun
// pulses for one cycle.
//
// Parameters:
//   WIDTH      data word width, 2..64
//   MSB_FIRST  1: first received bit ends up in dout[WIDTH-1]
//              0: first received bit ends up in dout[0]
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high; highest priority
//   din_valid   din is sampled when high
//   din         serial data bit
//   clear       aborts the partial word (shift register and bit_cnt)
//   dout        word held in the output register
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer takes dout when dout_valid && dout_ready
//   bit_cnt     number of bits collected in the current partial word
//   overrun     one-cycle pulse when a completed word is dropped
//   parity_err  (PARITY_CHECK_EN only) odd parity seen over the frame
//               now loaded in dout
//
// Optional feature macro: PARITY_CHECK_EN
//   Each frame carries WIDTH data bits followed by one even-parity bit.
//   The parity bit is checked but is never placed in dout.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_valid,
  input  logic                       din,
  input  logic                       clear,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       overrun
`ifdef PARITY_CHECK_EN
  ,
  output logic                       parity_err
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PARITY_CHECK_EN
  // The extra bit index WIDTH carries the parity bit.
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shift;
  logic [WIDTH-1:0] candidate;
  logic             accept;
  logic             complete;
  logic             load;
  logic             drop;
  logic             consume;
  logic             shift_en;

  always_comb begin
    sreg_shift = sreg;
    if (MSB_FIRST) sreg_shift = {sreg[WIDTH-2:0], din};
    else           sreg_shift = {din, sreg[WIDTH-1:1]};
  end

  // clear wins over an accept on the same edge, so no completion can coincide with it.
  assign accept   = din_valid && !clear;
  assign complete = accept && (bit_cnt == CNT_W'(LAST));
  assign consume  = dout_valid && dout_ready;
  // The holding register is free if it is empty or being drained on this edge.
  assign load     = complete && (!dout_valid || dout_ready);
  assign drop     = complete && dout_valid && !dout_ready;

`ifdef PARITY_CHECK_EN
  // The parity bit is only checked. It is not shifted into the data register.
  assign shift_en  = accept && !complete;
  assign candidate = sreg;
`else
  assign shift_en  = accept;
  assign candidate = sreg_shift;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg       <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (clear) begin
        sreg    <= '0;
        bit_cnt <= '0;
      end else if (din_valid) begin
        if (shift_en) sreg <= sreg_shift;
        bit_cnt <= complete ? '0 : bit_cnt + CNT_W'(1);
      end

      if (load) begin
        dout       <= candidate;
        dout_valid <= 1'b1;
      end else if (consume) begin
        dout_valid <= 1'b0;
      end

      overrun <= drop;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)       parity_err <= 1'b0;
    else if (load) parity_err <= ^{sreg, din};
  end
`endif

endmodule
